// File: rtl/i2c_slave_regs_if.sv
// I2C bus pins seen by the i2c_slave_regs target.
// The master side supplies the (wired-AND) SCL/SDA levels; the target side
// returns its open-drain pull-low request on sda_oe.
interface i2c_slave_regs_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a small byte-wide register file.
// SCL/SDA are oversampled on clk (2-flop sync + 1 edge-detect flop); nothing
// is clocked by SCL. SDA is only ever pulled low (sda_oe=1) on a synced SCL
// falling edge. Optional build macro I2C_SLV_AUTOINC_EN enables pointer
// auto-increment after committed write bytes and ACKed read bytes.
//
// state       | meaning
// ------------|----------------------------------------------------------
// S_IDLE      | bus free, waiting for START
// S_ADDR      | shifting 7-bit address + R/W
// S_ADDR_ACK  | pulling SDA low for the address ACK clock
// S_REG       | shifting register pointer byte
// S_REG_ACK   | pulling SDA low for the pointer ACK clock
// S_WDATA     | shifting a write data byte
// S_WDATA_ACK | byte committed, pulling SDA low for its ACK clock
// S_RDATA     | driving read data bits MSB first
// S_RDATA_ACK | SDA released, sampling the master ACK/NACK
// S_WAIT      | not addressed or NACKed; ignore bus until START/STOP
module i2c_slave_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h2A,
    parameter int         REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    i2c_slave_regs_if.slave   bus,
    output logic              busy,
    output logic              wr_pulse,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] host_addr,
    output logic [7:0]        host_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    state_t              r_state, w_state_nx;
    logic                r_scl_s1, r_scl_s2, r_scl_d;
    logic                r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0]          r_bit_cnt, w_cnt_nx;
    logic [7:0]          r_shift, w_shift_nx;
    logic [REG_AW-1:0]   r_ptr, w_ptr_nx, w_ptr_adv;
    logic                r_ack_seen, w_ack_nx;
    logic [7:0]          r_rd_byte, w_rd_nx;
    logic                r_sda_oe, w_oe_nx;
    logic                r_busy, w_busy_nx;
    logic                w_we;
    logic                r_wr_pulse;
    logic [REG_AW-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic [7:0]          r_regs [2**REG_AW];

    logic                w_scl_rise, w_scl_fall, w_start, w_stop, w_bit, w_last_bit;
    logic [7:0]          w_byte, w_cur_reg;

    // Bus level synchronizers plus one flop of history for edge detection.
    // Reset to 1 so an idle (high) bus produces no spurious edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_in; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= bus.sda_in; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    // SDA edges while we pull low are our own doing, never a bus condition.
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d & ~r_sda_oe;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d & ~r_sda_oe;
    assign w_bit      = r_sda_s2;
    assign w_byte     = {r_shift[6:0], w_bit};
    assign w_last_bit = w_scl_rise & (r_bit_cnt == 3'd7);
    assign w_cur_reg  = r_regs[r_ptr];

`ifdef I2C_SLV_AUTOINC_EN
    assign w_ptr_adv = r_ptr + {{(REG_AW-1){1'b0}}, 1'b1};
`else
    assign w_ptr_adv = r_ptr;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    // Next-state decode; START/STOP override every state.
    always_comb begin
        w_state_nx = r_state;
        if (w_start) begin
            w_state_nx = S_ADDR;
        end else if (w_stop) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:      if (w_last_bit)
                                 w_state_nx = (w_byte[7:1] == SLV_ADDR) ? S_ADDR_ACK : S_WAIT;
                S_REG:       if (w_last_bit) w_state_nx = S_REG_ACK;
                S_WDATA:     if (w_last_bit) w_state_nx = S_WDATA_ACK;
                S_RDATA:     if (w_last_bit) w_state_nx = S_RDATA_ACK;
                S_ADDR_ACK:  if (w_scl_fall && r_ack_seen)
                                 w_state_nx = r_shift[0] ? S_RDATA : S_REG;
                S_REG_ACK,
                S_WDATA_ACK: if (w_scl_fall && r_ack_seen) w_state_nx = S_WDATA;
                S_RDATA_ACK: begin
                    if (w_scl_rise && !r_ack_seen && w_bit)
                        w_state_nx = S_WAIT;
                    else if (w_scl_fall && r_ack_seen)
                        w_state_nx = S_RDATA;
                end
                default: ;
            endcase
        end
    end

    // Next values of the datapath/outputs. r_ack_seen marks that the 9th
    // rising edge has passed, so the following falling edge ends the ACK slot.
    always_comb begin
        w_oe_nx    = r_sda_oe;
        w_busy_nx  = r_busy;
        w_cnt_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_ptr_nx   = r_ptr;
        w_ack_nx   = r_ack_seen;
        w_rd_nx    = r_rd_byte;
        w_we       = 1'b0;
        if (w_start) begin
            w_oe_nx   = 1'b0;
            w_cnt_nx  = 3'd0;
            w_ack_nx  = 1'b0;
            w_busy_nx = 1'b0;
        end else if (w_stop) begin
            w_oe_nx   = 1'b0;
            w_cnt_nx  = 3'd0;
            w_ack_nx  = 1'b0;
            w_busy_nx = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx = w_byte;
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nx = 3'd0;
                            w_ack_nx = 1'b0;
                            if (r_state == S_ADDR && w_byte[7:1] == SLV_ADDR)
                                w_busy_nx = 1'b1;
                            if (r_state == S_REG)
                                w_ptr_nx = w_byte[REG_AW-1:0];
                            if (r_state == S_WDATA) begin
                                w_we     = 1'b1;
                                w_ptr_nx = w_ptr_adv;
                            end
                        end else begin
                            w_cnt_nx = r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_nx = 1'b1;
                    end else if (w_scl_fall) begin
                        if (!r_ack_seen) begin
                            w_oe_nx = 1'b1;
                        end else if (r_state == S_ADDR_ACK && r_shift[0]) begin
                            w_rd_nx = w_cur_reg;
                            w_oe_nx = ~w_cur_reg[7];
                        end else begin
                            w_oe_nx = 1'b0;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nx = 3'd0;
                            w_ack_nx = 1'b0;
                        end else begin
                            w_cnt_nx = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall) begin
                        w_oe_nx = ~r_rd_byte[~r_bit_cnt];
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (!r_ack_seen && !w_bit) begin
                            w_ack_nx = 1'b1;
                            w_ptr_nx = w_ptr_adv;
                        end
                    end else if (w_scl_fall) begin
                        if (!r_ack_seen) begin
                            w_oe_nx = 1'b0;
                        end else begin
                            w_rd_nx = w_cur_reg;
                            w_oe_nx = ~w_cur_reg[7];
                        end
                    end
                end
                S_WAIT:  w_oe_nx = 1'b0;
                default: ;
            endcase
        end
    end

    // Datapath, outputs and write strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_ptr      <= '0;
            r_ack_seen <= 1'b0;
            r_rd_byte  <= 8'h00;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
        end else begin
            r_sda_oe   <= w_oe_nx;
            r_busy     <= w_busy_nx;
            r_bit_cnt  <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_ptr      <= w_ptr_nx;
            r_ack_seen <= w_ack_nx;
            r_rd_byte  <= w_rd_nx;
            r_wr_pulse <= w_we;
            if (w_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
        end
    end

    // Register file, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= 8'h00;
        end else if (w_we) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    assign bus.sda_oe = r_sda_oe;
    assign busy       = r_busy;
    assign wr_pulse   = r_wr_pulse;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign host_rdata = r_regs[host_addr];

endmodule
